// File: rtl/onehot_decode_pipe.sv
// Purpose: dual-port address-to-one-hot decoder with one register stage and optional A/B collision handling.
// Latency: one clock; inputs captured on a rising edge of clk appear on the outputs right after that edge.
// Backpressure: stall=1 freezes every registered output and the collision counter; inputs are ignored meanwhile.
//
// Ports:
//   clk, rst          single clock; asynchronous active-high reset clears all registered outputs
//   stall             hold all registered state
//   a_vld, a_addr     port A request
//   b_vld, b_addr     port B request
//   a_sel, b_sel      registered one-hot selects
//   any_sel           a_sel | b_sel, combinational from the registers
//   out_vld           registered: either port valid in the captured cycle
//   conflict          registered: captured cycle had an A/B collision (B wins)
//   conflict_cnt      saturating count of captured collisions
//
// Build option: define ONEHOT_DECODE_CONFLICT_EN to enable collision detection,
// B-wins arbitration and the collision counter. Without it the ports decode
// independently and conflict/conflict_cnt are tied to zero.

module onehot_decode_pipe #(
  parameter int ADDR_W    = 5,
  parameter int OUT_W     = 2**ADDR_W,
  parameter int ZERO_MASK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              a_vld,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              b_vld,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [OUT_W-1:0]  a_sel,
  output logic [OUT_W-1:0]  b_sel,
  output logic [OUT_W-1:0]  any_sel,
  output logic              out_vld,
  output logic              conflict,
  output logic [7:0]        conflict_cnt
);

  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  // A port "hits" when it is valid and its bit is not suppressed by the
  // hard-wired zero register at address 0.
  logic             a_hit;
  logic             b_hit;
  logic [OUT_W-1:0] a_dec;
  logic [OUT_W-1:0] b_dec;
  logic [OUT_W-1:0] a_nxt;

  assign a_hit = a_vld && !((ZERO_MASK != 0) && (a_addr == '0));
  assign b_hit = b_vld && !((ZERO_MASK != 0) && (b_addr == '0));
  assign a_dec = a_hit ? (ONE << a_addr) : '0;
  assign b_dec = b_hit ? (ONE << b_addr) : '0;

`ifdef ONEHOT_DECODE_CONFLICT_EN
  logic       coll;
  logic       conflict_q;
  logic [7:0] cnt_q;

  // Only an unsuppressed shared bit counts as a collision; B keeps the bit.
  assign coll  = a_hit && b_hit && (a_addr == b_addr);
  assign a_nxt = coll ? '0 : a_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else if (!stall) begin
      conflict_q <= coll;
      if (coll && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;
`else
  assign a_nxt        = a_dec;
  assign conflict     = 1'b0;
  assign conflict_cnt = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sel   <= '0;
      b_sel   <= '0;
      out_vld <= 1'b0;
    end else if (!stall) begin
      a_sel   <= a_nxt;
      b_sel   <= b_dec;
      // Valid reflects the request, not whether a bit survived the zero mask.
      out_vld <= a_vld || b_vld;
    end
  end

  assign any_sel = a_sel | b_sel;

endmodule
